// File: rtl/axis_frame_replay_buffer.sv
// AXI-Stream frame buffer: captures one input frame into registers,
// then replays it PASSES times on the master side.
module axis_frame_replay_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int PASSES     = 3,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int PASS_W    = $clog2(PASSES + 1)
) (
    input  logic                  axi_clock_i,
    input  logic                  axi_reset_i,
    input  logic                  s_axis_valid_i,
    input  logic [DATA_WIDTH-1:0] s_axis_data_i,
    input  logic                  s_axis_last_i,
    output logic                  s_axis_ready_o,
    input  logic                  m_axis_ready_i,
    output logic                  m_axis_valid_o,
    output logic [DATA_WIDTH-1:0] m_axis_data_o,
    output logic                  m_axis_last_o,
    output logic [PASS_W-1:0]     m_axis_pass_o,
    output logic [ADDR_W:0]       frame_len_o,
    output logic                  overflow_o
);

    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);

    typedef enum logic {
        FILL,
        REPLAY
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  armed;
    logic [ADDR_W:0]       wr_cnt;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [PASS_W-1:0]     pass_cnt;
    logic [ADDR_W:0]       frame_len;
    logic                  overflow;
    logic                  full;
    logic                  in_xfer;
    logic                  out_xfer;
    logic                  rd_last;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // armed holds input ready low until the first clock after reset release
    assign in_xfer  = (state == FILL) && armed && s_axis_valid_i;
    assign out_xfer = (state == REPLAY) && m_axis_ready_i;
    assign full     = (wr_cnt == DEPTH_C);
    assign rd_last  = ({1'b0, rd_ptr} == frame_len - 1'b1);

    assign m_axis_pass_o = pass_cnt;
    assign frame_len_o   = frame_len;
    assign overflow_o    = overflow;

    always_comb begin
        state_nxt      = state;
        s_axis_ready_o = 1'b0;
        m_axis_valid_o = 1'b0;
        m_axis_data_o  = '0;
        m_axis_last_o  = 1'b0;
        unique case (state)
            FILL: begin
                s_axis_ready_o = armed;
                if (in_xfer && s_axis_last_i)
                    state_nxt = REPLAY;
            end
            REPLAY: begin
                m_axis_valid_o = 1'b1;
                m_axis_data_o  = mem[rd_ptr];
                m_axis_last_o  = rd_last;
                if (out_xfer && rd_last && pass_cnt == PASS_LAST)
                    state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge axi_clock_i or posedge axi_reset_i) begin
        if (axi_reset_i) begin
            state     <= FILL;
            armed     <= 1'b0;
            wr_cnt    <= '0;
            rd_ptr    <= '0;
            pass_cnt  <= '0;
            frame_len <= '0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (in_xfer) begin
                // beats past DEPTH are swallowed so the source never stalls
                if (full)
                    overflow <= 1'b1;
                else
                    wr_cnt <= wr_cnt + 1'b1;
                if (s_axis_last_i) begin
                    wr_cnt    <= '0;
                    frame_len <= full ? DEPTH_C : wr_cnt + 1'b1;
                end
            end
            if (out_xfer) begin
                if (rd_last) begin
                    rd_ptr   <= '0;
                    pass_cnt <= (pass_cnt == PASS_LAST) ? '0 : pass_cnt + 1'b1;
                end else begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge axi_clock_i) begin
        if (in_xfer && !full)
            mem[wr_cnt[ADDR_W-1:0]] <= s_axis_data_i;
    end

endmodule

// File: tb/tb_axis_frame_replay_buffer.sv
// Directed and randomized bench for axis_frame_replay_buffer with a
// queue-based reference model of capture and replay.
module tb_axis_frame_replay_buffer;

    localparam int DW     = 32;
    localparam int DEPTH  = 16;
    localparam int PASSES = 3;
    localparam int AW     = $clog2(DEPTH);
    localparam int PW     = $clog2(PASSES + 1);

    typedef logic [DW-1:0] word_t;
    typedef word_t wq_t[$];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          m_ready = 1'b0;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [PW-1:0] m_pass;
    logic [AW:0]   frame_len;
    logic          overflow;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    word_t exp_d[$];
    bit    exp_l[$];
    int    exp_p[$];
    int    ref_len = 0;
    bit    ref_ovf = 1'b0;

    axis_frame_replay_buffer #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .PASSES    (PASSES)
    ) dut (
        .axi_clock_i   (clk),
        .axi_reset_i   (rst),
        .s_axis_valid_i(s_valid),
        .s_axis_data_i (s_data),
        .s_axis_last_i (s_last),
        .s_axis_ready_o(s_ready),
        .m_axis_ready_i(m_ready),
        .m_axis_valid_o(m_valid),
        .m_axis_data_o (m_data),
        .m_axis_last_o (m_last),
        .m_axis_pass_o (m_pass),
        .frame_len_o   (frame_len),
        .overflow_o    (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected output: first min(n, DEPTH) beats, repeated PASSES times
    task automatic model_frame(input wq_t f);
        int n;
        n = (f.size() > DEPTH) ? DEPTH : f.size();
        if (f.size() > DEPTH) ref_ovf = 1'b1;
        ref_len = n;
        for (int p = 0; p < PASSES; p++)
            for (int i = 0; i < n; i++) begin
                exp_d.push_back(f[i]);
                exp_l.push_back(i == n - 1);
                exp_p.push_back(p);
            end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_m_pass"}, m_pass, 0);
        chk({tag, "_frame_len"}, frame_len, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_s_ready"}, s_ready, 0);
    endtask

    // Inputs are driven and outputs sampled on the falling edge
    task automatic send(input wq_t f, input bit hold, input int max_gap,
                        output int first_at);
        int g;
        first_at = -1;
        for (int i = 0; i < f.size(); i++) begin
            s_valid = 1'b1;
            s_data  = f[i];
            s_last  = (i == f.size() - 1);
            g = 0;
            while (!s_ready && g < 400) begin
                @(negedge clk);
                g++;
            end
            chk("s_accept_timeout", g < 400, 1);
            if (i == 0) first_at = cyc + 1;
            @(negedge clk);
            if (!s_last && max_gap > 0) begin
                g = $urandom_range(0, max_gap);
                if (g > 0) begin
                    s_valid = 1'b0;
                    repeat (g) @(negedge clk);
                end
            end
        end
        if (!hold) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
        chk("replay_latency", m_valid, 1);
    endtask

    // mode 0: ready held high, 1: toggling, 2: random
    task automatic drain(input int mode, output int last_at);
        int n;
        int g;
        int cycles;
        n = exp_d.size();
        last_at = -1;
        g = 0;
        while (!m_valid && g < 400) begin
            @(negedge clk);
            g++;
        end
        chk("replay_start_timeout", g < 400, 1);
        cycles = 0;
        while (exp_d.size() > 0 && g < 5000) begin
            case (mode)
                0: m_ready = 1'b1;
                1: m_ready = (cycles % 2 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            chk("m_valid", m_valid, 1);
            chk("s_ready_replay", s_ready, 0);
            chk("m_data", m_data, exp_d[0]);
            chk("m_last", m_last, exp_l[0]);
            chk("m_pass", m_pass, exp_p[0]);
            if (m_ready) begin
                if (exp_d.size() == 1) last_at = cyc + 1;
                void'(exp_d.pop_front());
                void'(exp_l.pop_front());
                void'(exp_p.pop_front());
            end
            cycles++;
            g++;
            @(negedge clk);
        end
        m_ready = 1'b0;
        chk("drain_remaining", exp_d.size(), 0);
        if (mode == 0) chk("replay_cycles", cycles, n);
        chk("fill_s_ready", s_ready, 1);
        chk("fill_m_valid", m_valid, 0);
        chk("fill_m_data", m_data, 0);
        chk("fill_m_last", m_last, 0);
        chk("frame_len", frame_len, ref_len);
        chk("overflow", overflow, ref_ovf);
    endtask

    initial begin
        wq_t f;
        wq_t f2;
        int t0;
        int t1;
        int len;

        #2;
        chk_reset_state("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("s_ready_after_release", s_ready, 1);

        // Reference frame, ready held high
        f = '{32'hBFE147AE, 32'hC01820C4, 32'h40558106,
              32'hC04B74BC, 32'hBF59DB22};
        model_frame(f);
        send(f, 1'b0, 0, t0);
        drain(0, t1);

        // Same frame, ready toggling
        model_frame(f);
        send(f, 1'b0, 0, t0);
        drain(1, t1);

        // Single beat frame
        f = '{32'h3F800000};
        model_frame(f);
        send(f, 1'b0, 0, t0);
        drain(0, t1);

        // Exactly DEPTH beats: no overflow
        f = {};
        for (int i = 0; i < DEPTH; i++) f.push_back(word_t'(i + 100));
        model_frame(f);
        send(f, 1'b0, 0, t0);
        drain(2, t1);

        // DEPTH+3 beats: overflow, replay truncated
        f = {};
        for (int i = 1; i <= DEPTH + 3; i++) f.push_back(word_t'(i));
        model_frame(f);
        send(f, 1'b0, 0, t0);
        drain(0, t1);

        // Asynchronous reset in the middle of a replay
        f = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        send(f, 1'b0, 0, t0);
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        m_ready = 1'b0;
        chk_reset_state("mid_replay_rst");
        @(negedge clk);
        rst = 1'b0;
        ref_len = 0;
        ref_ovf = 1'b0;
        @(negedge clk);
        chk("s_ready_after_rst", s_ready, 1);

        // Partial frame discarded by a reset
        s_valid = 1'b1;
        s_last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_data = word_t'(32'hDEAD0000 + i);
            @(negedge clk);
        end
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_reset_state("mid_fill_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        f = '{32'hA5A5A5A5, 32'h5A5A5A5A};
        model_frame(f);
        send(f, 1'b0, 0, t0);
        drain(0, t1);

        // Back-to-back frames, source valid held high
        f  = '{32'h01010101, 32'h02020202, 32'h03030303};
        f2 = '{32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 32'h0D0D0D0D};
        t0 = -1;
        t1 = -1;
        fork
            begin
                int dummy;
                send(f, 1'b1, 0, dummy);
                send(f2, 1'b0, 0, t1);
            end
            begin
                int dummy;
                model_frame(f);
                drain(0, t0);
                model_frame(f2);
                drain(0, dummy);
            end
        join
        chk("b2b_first_accept", t1, t0 + 1);

        // Randomized frames, gaps and backpressure
        for (int k = 0; k < 10; k++) begin
            len = $urandom_range(1, DEPTH + 3);
            f = {};
            for (int i = 0; i < len; i++) f.push_back(word_t'($urandom));
            model_frame(f);
            send(f, 1'b0, 2, t0);
            drain(k % 3, t1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
